// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with valid/ready request, registered response,
// configurable read latency and error reporting for misaligned/out-of-range access.
module data_memory_ctrl #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         lat_q, lat_d;
  logic             wr_pend_q, wr_pend_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [31:0]      mem_q [DEPTH];

  mem_req_t         in_req;
  mem_req_t         cur_req;
  logic             accept;
  logic [31:0]      rd_word;
  logic             wr_en;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic [IDX_W-1:0] wr_idx;

  function automatic logic access_err(input mem_req_t r);
    logic bad;
    case (r.size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = r.addr[0];
      SZ_WORD: bad = |r.addr[1:0];
      default: bad = 1'b1;
    endcase
    return bad || (r.addr[31:2] >= 30'(DEPTH));
  endfunction

  // Shift the addressed lane(s) down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input mem_req_t r);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] res;
    sh_b = w >> {r.addr[1:0], 3'b000};
    sh_h = w >> {r.addr[1], 4'b0000};
    case (r.size)
      SZ_BYTE: res = r.uns ? {24'd0, sh_b[7:0]}  : {{24{sh_b[7]}}, sh_b[7:0]};
      SZ_HALF: res = r.uns ? {16'd0, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  assign in_req  = '{we: req_we, size: req_size, uns: req_unsigned,
                     addr: req_addr, wdata: req_wdata};
  // With zero latency RESP is entered on the accepting edge, before the latch.
  assign cur_req = accept ? in_req : lat_q;
  assign rd_word = mem_q[cur_req.addr[IDX_W+1:2]];

  // Store path: commits on the first edge after acceptance unless in reset.
  always_comb begin
    wr_en   = wr_pend_q && !rst && !access_err(lat_q);
    wr_idx  = lat_q.addr[IDX_W+1:2];
    wr_be   = 4'hF;
    wr_data = lat_q.wdata;
    case (lat_q.size)
      SZ_BYTE: begin
        wr_be   = 4'b0001 << lat_q.addr[1:0];
        wr_data = {4{lat_q.wdata[7:0]}};
      end
      SZ_HALF: begin
        wr_be   = lat_q.addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{lat_q.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_d        = lat_q;
    wr_pend_d    = 1'b0;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_d     = in_req;
          wr_pend_d = req_we;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Response data is captured on the edge that enters RESP.
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      err_d   = access_err(cur_req);
      rdata_d = (err_d || cur_req.we) ? 32'd0 : load_ext(rd_word, cur_req);
    end
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lat_q        <= '0;
      wr_pend_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      wr_pend_q    <= wr_pend_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: a zero-latency 16-word instance and a 3-cycle-latency
// default-depth instance, driven through one request task each transaction.
module tb_data_memory_ctrl;

  localparam int unsigned LAT_B = 3;

  logic clk;
  logic rst_a, rst_b;

  logic        valid_a, ready_a, we_a, uns_a, rvalid_a, err_a;
  logic [1:0]  size_a;
  logic [31:0] addr_a, wdata_a, rdata_a;

  logic        valid_b, ready_b, we_b, uns_b, rvalid_b, err_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int n_checks = 0;
  int n_pass   = 0;

  data_memory_ctrl #(.DEPTH(16), .LATENCY(0)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid(valid_a), .req_ready(ready_a), .req_we(we_a), .req_size(size_a),
    .req_unsigned(uns_a), .req_addr(addr_a), .req_wdata(wdata_a),
    .resp_valid(rvalid_a), .resp_rdata(rdata_a), .resp_err(err_a)
  );

  data_memory_ctrl #(.DEPTH(1024), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(valid_b), .req_ready(ready_b), .req_we(we_b), .req_size(size_b),
    .req_unsigned(uns_b), .req_addr(addr_b), .req_wdata(wdata_b),
    .resp_valid(rvalid_b), .resp_rdata(rdata_b), .resp_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic rvld(input int d);
    return (d == 0) ? rvalid_a : rvalid_b;
  endfunction

  task automatic drive(input int d, input logic v, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      valid_a = v; we_a = we; size_a = size; uns_a = uns; addr_a = addr; wdata_a = wdata;
    end else begin
      valid_b = v; we_b = we; size_b = size; uns_b = uns; addr_b = addr; wdata_b = wdata;
    end
  endtask

  // One transaction; checks response latency, pulse width and ready timing.
  task automatic do_req(input int d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er);
    int n;
    int k;
    int lat;
    lat = (d == 0) ? 0 : int'(LAT_B);
    drive(d, 1'b1, we, size, uns, addr, wdata);
    n = 0;
    while (!rdy(d) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("hs_ready", 32'(rdy(d)), 32'd1);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    k = 1;
    while (!rvld(d) && k < 20) begin
      check("busy_ready", 32'(rdy(d)), 32'd0);
      @(posedge clk); #1; k++;
    end
    check("resp_lat", 32'(k), 32'(lat + 1));
    check("resp_ready", 32'(rdy(d)), 32'd0);
    rd = (d == 0) ? rdata_a : rdata_b;
    er = (d == 0) ? err_a : err_b;
    @(posedge clk); #1;
    check("resp_pulse", 32'(rvld(d)), 32'd0);
    check("idle_ready", 32'(rdy(d)), 32'd1);
  endtask

  task automatic xfer(input int d, input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    do_req(d, we, size, uns, addr, wdata, rd, er);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_er));
  endtask

  logic [31:0] bb_addr [4];
  logic [31:0] bb_exp  [4];
  int          acc_cyc [4];
  int          rsp_cyc [4];

  initial begin
    int cyc, nacc, nrsp, seen;
    logic pre_rdy, pre_v;

    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
    check("rst_rvalid", 32'(rvalid_a), 32'd0);
    check("rst_rdata", rdata_a, 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("post_rst_ready", 32'(ready_a), 32'd1);

    // Zero-latency instance: word, byte and half paths.
    xfer(0, "st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    xfer(0, "ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    xfer(0, "st_w00", 1'b1, 2'b10, 1'b0, 32'h00, 32'h11223344, 32'd0, 1'b0);
    xfer(0, "st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h00000000, 32'd0, 1'b0);
    xfer(0, "st_b21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF80, 32'd0, 1'b0);
    xfer(0, "ld_bs21", 1'b0, 2'b00, 1'b0, 32'h21, 32'd0, 32'hFFFFFF80, 1'b0);
    xfer(0, "ld_bu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'd0, 32'h00000080, 1'b0);
    xfer(0, "ld_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h00008000, 1'b0);
    xfer(0, "st_b23", 1'b1, 2'b00, 1'b0, 32'h23, 32'h0000007F, 32'd0, 1'b0);
    xfer(0, "ld_w20b", 1'b0, 2'b10, 1'b1, 32'h20, 32'd0, 32'h7F008000, 1'b0);
    xfer(0, "st_w30", 1'b1, 2'b10, 1'b0, 32'h30, 32'hAABBCCDD, 32'd0, 1'b0);
    xfer(0, "st_h32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h00001234, 32'd0, 1'b0);
    xfer(0, "ld_hs32", 1'b0, 2'b01, 1'b0, 32'h32, 32'd0, 32'h00001234, 1'b0);
    xfer(0, "ld_w30", 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 32'h1234CCDD, 1'b0);
    xfer(0, "ld_hs30", 1'b0, 2'b01, 1'b0, 32'h30, 32'd0, 32'hFFFFCCDD, 1'b0);
    xfer(0, "ld_hu30", 1'b0, 2'b01, 1'b1, 32'h30, 32'd0, 32'h0000CCDD, 1'b0);

    // Error responses; faulting stores must leave memory untouched.
    xfer(0, "err_w06", 1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 32'd0, 1'b1);
    xfer(0, "err_h03", 1'b1, 2'b01, 1'b0, 32'h03, 32'h0000FFFF, 32'd0, 1'b1);
    xfer(0, "ld_w00", 1'b0, 2'b10, 1'b0, 32'h00, 32'd0, 32'h11223344, 1'b0);
    xfer(0, "err_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1);
    xfer(0, "err_oor", 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'd0, 1'b1);
    xfer(0, "err_st_oor", 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'd0, 1'b1);
    xfer(0, "ld_w00b", 1'b0, 2'b10, 1'b0, 32'h00, 32'd0, 32'h11223344, 1'b0);
    xfer(0, "ld_bs_oor", 1'b0, 2'b00, 1'b0, 32'h43, 32'd0, 32'd0, 1'b1);

    // Latency-3 instance: preload, then back-to-back loads with valid held high.
    for (int i = 0; i < 4; i++) begin
      bb_addr[i] = 32'h100 + 32'(4 * i);
      bb_exp[i]  = 32'hA5000000 + 32'(i * 32'h00010203);
      xfer(1, "pre_st", 1'b1, 2'b10, 1'b0, bb_addr[i], bb_exp[i], 32'd0, 1'b0);
    end

    cyc  = 0;
    nacc = 0;
    nrsp = 0;
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, bb_addr[0], 32'd0);
    while (nrsp < 4 && cyc < 60) begin
      pre_rdy = ready_b;
      pre_v   = valid_b;
      @(posedge clk); #1;
      cyc++;
      if (pre_rdy && pre_v) begin
        if (nacc < 4) acc_cyc[nacc] = cyc - 1;
        nacc++;
        if (nacc < 4) drive(1, 1'b1, 1'b0, 2'b10, 1'b0, bb_addr[nacc], 32'd0);
        else          drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      end
      if (rvalid_b) begin
        if (nrsp < 4) begin
          check("bb_rdata", rdata_b, bb_exp[nrsp]);
          rsp_cyc[nrsp] = cyc;
        end
        nrsp++;
      end
    end
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    check("bb_accepts", 32'(nacc), 32'd4);
    check("bb_resps", 32'(nrsp), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < nacc && i < nrsp) check("bb_resp_delay", 32'(rsp_cyc[i] - acc_cyc[i]), 32'd4);
      if (i > 0 && i < nacc) check("bb_accept_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);
    end
    @(posedge clk); #1;

    // Reset during the second WAIT cycle of a load drops its response.
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    check("mr_ready", 32'(ready_b), 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    check("mr_wait1_ready", 32'(ready_b), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    #1;
    check("mr_rst_ready", 32'(ready_b), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    check("mr_post_ready", 32'(ready_b), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rvalid_b) seen++;
      @(posedge clk); #1;
    end
    check("mr_no_resp", 32'(seen), 32'd0);
    xfer(1, "mr_after", 1'b0, 2'b10, 1'b0, 32'h104, 32'd0, bb_exp[1], 1'b0);
    xfer(1, "l3_bu", 1'b0, 2'b00, 1'b1, 32'h10B, 32'd0, 32'h000000A5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
